// File: rtl/tnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tnn_pkg
// Purpose  : Shared types and constants for the TNN feature loader.
// Revision : 1.0 - initial release
// ============================================================================
package tnn_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  localparam int FRAME_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/tnn_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : tnn_quantizer
// Purpose  : Round-to-nearest reduction of a raw sample to FEAT_BITS, saturating.
// Revision : 1.0 - initial release
// ============================================================================
module tnn_quantizer #(
  parameter int IN_BITS   = 8,
  parameter int FEAT_BITS = 4
) (
  input  logic [IN_BITS-1:0]   i_sample,
  output logic [FEAT_BITS-1:0] o_feat
);

  localparam int c_SHIFT = IN_BITS - FEAT_BITS;

  generate
    if (c_SHIFT == 0) begin : g_passthru
      assign o_feat = i_sample;
    end else begin : g_round
      localparam logic [IN_BITS:0] c_HALF = {{IN_BITS{1'b0}}, 1'b1} << (c_SHIFT - 1);
      localparam logic [IN_BITS:0] c_MAX  = {{(IN_BITS + 1 - FEAT_BITS){1'b0}}, {FEAT_BITS{1'b1}}};

      logic [IN_BITS:0] w_sum;
      logic [IN_BITS:0] w_shift;

      // One extra bit keeps the rounding carry of a full-scale sample.
      assign w_sum   = {1'b0, i_sample} + c_HALF;
      assign w_shift = w_sum >> c_SHIFT;
      assign o_feat  = (w_shift > c_MAX) ? c_MAX[FEAT_BITS-1:0] : w_shift[FEAT_BITS-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tnn_feature_loader.sv
`default_nettype none
// ============================================================================
// Module   : tnn_feature_loader
// Purpose  : Packs quantized samples into a feature frame, waits for the
//            combinational classifier and hands its prediction downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tnn_feature_loader
  import tnn_pkg::*;
#(
  parameter int FEAT_CNT      = 12,
  parameter int FEAT_BITS     = 4,
  parameter int IN_BITS       = 8,
  parameter int CLASS_CNT     = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_BITS-1:0]            in_data,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [$clog2(CLASS_CNT)-1:0]  prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CLASS_CNT)-1:0]  out_class,
  output logic                          err_frame,
  output logic [FRAME_CNT_W-1:0]        frame_cnt
);

  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IDX_W-1:0] c_IDX_LAST    = IDX_W'(FEAT_CNT - 1);
  localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] c_SETTLE_ONE  = CNT_W'(1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [IDX_W-1:0]                r_idx;
  logic [CNT_W-1:0]                r_settle_cnt;
  logic [FEAT_CNT*FEAT_BITS-1:0]   r_features;
  logic [$clog2(CLASS_CNT)-1:0]    r_out_class;
  logic                            r_err;
  logic [FRAME_CNT_W-1:0]          r_frame_cnt;

  logic                            w_in_ready;
  logic                            w_out_valid;
  logic                            w_accept;
  logic                            w_at_last;
  logic                            w_settle_done;
  logic [FEAT_BITS-1:0]            w_q;

  tnn_quantizer #(
    .IN_BITS   (IN_BITS),
    .FEAT_BITS (FEAT_BITS)
  ) u_quant (
    .i_sample (in_data),
    .o_feat   (w_q)
  );

  assign in_ready      = w_in_ready & ~rst;
  assign w_accept      = in_valid & in_ready;
  assign w_at_last     = (r_idx == c_IDX_LAST);
  assign w_settle_done = (r_state == ST_SETTLE) && (r_settle_cnt == c_SETTLE_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        w_in_ready = 1'b1;
        // A missing in_last on the final slot still completes the frame.
        if (w_accept && w_at_last) begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_settle_done) begin
          w_state_nxt = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_features   <= '0;
      r_out_class  <= '0;
      r_err        <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_err <= w_accept && (w_at_last ? ~in_last : in_last);

      if (w_accept) begin
        for (int k = 0; k < FEAT_CNT; k++) begin
          if (r_idx == IDX_W'(k)) begin
            r_features[k*FEAT_BITS +: FEAT_BITS] <= w_q;
          end
        end
        // Early in_last drops the frame; stale slots get overwritten later.
        r_idx        <= (w_at_last || in_last) ? '0 : r_idx + 1'b1;
        r_settle_cnt <= c_SETTLE_LOAD;
      end

      if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
        if (w_settle_done) begin
          r_out_class <= prediction;
        end
      end

      if (w_out_valid && out_ready) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign out_valid = w_out_valid;
  assign features  = r_features;
  assign out_class = r_out_class;
  assign err_frame = r_err;
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
